// File: rtl/default_slave_pkg.sv
// Shared AXI definitions: width macros, default-slave FSM state types and response codes.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

package default_slave_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/default_slave.sv
// AXI default slave: every transaction gets a DECERR reply; optional error log via DEFAULT_SLAVE_ERRLOG_EN.
// Latency 1 cycle per phase (AW->W, WLAST->B, AR->R); B and R hold stable until BREADY/RREADY.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module default_slave
  import default_slave_pkg::*;
#(
  parameter int IDW = `AXI_IDS_BITS,
  parameter int DW  = `AXI_DATA_BITS
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [IDW-1:0]  AWID,
  input  logic [31:0]     AWADDR,
  input  logic [3:0]      AWLEN,
  input  logic            AWVALID,
  output logic            AWREADY,
  input  logic [DW-1:0]   WDATA,
  input  logic [DW/8-1:0] WSTRB,
  input  logic            WLAST,
  input  logic            WVALID,
  output logic            WREADY,
  output logic [IDW-1:0]  BID,
  output logic [1:0]      BRESP,
  output logic            BVALID,
  input  logic            BREADY,
  input  logic [IDW-1:0]  ARID,
  input  logic [31:0]     ARADDR,
  input  logic [3:0]      ARLEN,
  input  logic            ARVALID,
  output logic            ARREADY,
  output logic [IDW-1:0]  RID,
  output logic [DW-1:0]   RDATA,
  output logic [1:0]      RRESP,
  output logic            RLAST,
  output logic            RVALID,
  input  logic            RREADY,
  output logic            err_valid,
  output logic [31:0]     err_addr
);

  w_state_t       w_state, w_state_nxt;
  logic [IDW-1:0] bid_q, bid_nxt;

  r_state_t       r_state, r_state_nxt;
  logic [IDW-1:0] rid_q, rid_nxt;
  logic [3:0]     rlen_q, rlen_nxt;
  logic [3:0]     beat_q, beat_nxt;

  logic aw_hs;
  logic ar_hs;
  logic last_beat;

  assign aw_hs     = AWVALID && (w_state == W_IDLE);
  assign ar_hs     = ARVALID && (r_state == R_IDLE);
  assign last_beat = (beat_q == rlen_q);

  // ---------------- write channel ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      bid_q   <= '0;
    end else begin
      w_state <= w_state_nxt;
      bid_q   <= bid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    bid_nxt     = bid_q;
    case (w_state)
      W_IDLE: begin
        if (AWVALID) begin
          bid_nxt     = AWID;
          w_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        // Burst length is ignored; only WLAST ends the data phase.
        if (WVALID && WLAST) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        if (BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign AWREADY = (w_state == W_IDLE);
  assign WREADY  = (w_state == W_DATA);
  assign BVALID  = (w_state == W_RESP);
  assign BRESP   = (w_state == W_RESP) ? RESP_DECERR : RESP_OKAY;
  assign BID     = bid_q;

  // ---------------- read channel ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= R_IDLE;
      rid_q   <= '0;
      rlen_q  <= '0;
      beat_q  <= '0;
    end else begin
      r_state <= r_state_nxt;
      rid_q   <= rid_nxt;
      rlen_q  <= rlen_nxt;
      beat_q  <= beat_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    rid_nxt     = rid_q;
    rlen_nxt    = rlen_q;
    beat_nxt    = beat_q;
    case (r_state)
      R_IDLE: begin
        if (ARVALID) begin
          rid_nxt     = ARID;
          rlen_nxt    = ARLEN;
          beat_nxt    = '0;
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          // The counter never passes rlen_q, so a 16-beat burst cannot wrap.
          if (last_beat) r_state_nxt = R_IDLE;
          else           beat_nxt    = beat_q + 4'd1;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign ARREADY = (r_state == R_IDLE);
  assign RVALID  = (r_state == R_DATA);
  assign RLAST   = (r_state == R_DATA) && last_beat;
  assign RRESP   = (r_state == R_DATA) ? RESP_DECERR : RESP_OKAY;
  assign RID     = rid_q;
  assign RDATA   = '0;

  // ---------------- error log ----------------
`ifdef DEFAULT_SLAVE_ERRLOG_EN
  logic        err_valid_q;
  logic [31:0] err_addr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      if (aw_hs || ar_hs) err_valid_q <= 1'b1;
      // A write address wins when both channels handshake together.
      if (aw_hs)      err_addr_q <= AWADDR;
      else if (ar_hs) err_addr_q <= ARADDR;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;

  logic unused_inputs;
  assign unused_inputs = ^{AWLEN, WDATA, WSTRB};
`else
  assign err_valid = 1'b0;
  assign err_addr  = '0;

  logic unused_inputs;
  assign unused_inputs = ^{AWADDR, AWLEN, WDATA, WSTRB, ARADDR, aw_hs, ar_hs};
`endif

endmodule
